muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Iterative multi-cycle RV32M multiply/divide unit in the EX stage, beside the single-cycle integer ALU.
- Accepts one operation at a time over a start/ready handshake and runs a radix-2 shift-add (multiply) or restoring shift-subtract (divide) sequence.
- Presents a one-cycle done pulse with the result and holds a busy level for the pipeline stall logic.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must hold XLEN.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- start_i  input  1  operation request; accepted only when ready_o=1.
- funct3_i  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a_i  input  32  rs1 value: multiplicand or dividend.
- op_b_i  input  32  rs2 value: multiplier or divisor.
- flush_i  input  1  synchronous abort of any in-flight operation.
- ready_o  output  1  high in IDLE only.
- busy_o  output  1  high in CALC, FIX and DONE.
- done_o  output  1  one-cycle result-valid pulse.
- result_o  output  32  result register; holds its value until the next completion.

Behaviour:
- Reset (asynchronous, active-high; also mid-operation): state=IDLE, counter=0, result_o=0, done_o=0, busy_o=0, ready_o=1. A partially computed result is discarded.
- States:
  - IDLE: on start_i=1, capture funct3_i, operand magnitudes and result-sign flags; clear the accumulator and counter; go to CALC.
    - Signedness of magnitudes: MULH/DIV/REM take both operands signed. MULHSU takes op_a signed and op_b unsigned. MULHU/DIVU/REMU and MUL are unsigned; MUL low bits are sign-independent.
  - CALC: one iteration per cycle, 32 cycles; counter runs 0..31, then go to FIX.
    - Multiply: 33-bit add of the multiplicand into the upper accumulator when the multiplier LSB is 1, then shift the 64-bit product register right by 1.
    - Divide: shift the remainder:quotient register left by 1, then trial-subtract the divisor using 33-bit arithmetic. If the result is non-negative, commit it and set the quotient LSB.
  - FIX: apply two's-complement negation as required.
    - MUL: product[31:0]. MULH/MULHSU/MULHU: product[63:32], negated 64-bit product when signs differ.
    - DIV/DIVU: quotient; DIV quotient negated when signs differ.
    - REM/REMU: remainder; REM remainder takes the dividend's sign.
    - Register result_o and go to DONE.
  - DONE: done_o=1 for exactly one cycle, then go to IDLE.
- Latency: start accepted at edge 0; done_o high between edges 33 and 34; ready_o high again after edge 34. Back-to-back start at the first ready cycle is legal.
- start_i is ignored while ready_o=0. Operands are sampled only at acceptance; later changes have no effect.
- Divide by zero (op_b=0):
  - DIV/DIVU result 0xFFFFFFFF.
  - REM/REMU result is op_a.
  - Full 34-cycle latency without the optional feature.
- Signed overflow (DIV, op_a=0x80000000, op_b=0xFFFFFFFF): result 0x80000000. REM of the same operands: result 0.
- flush_i=1 in any non-IDLE state: go to IDLE on the next edge, no done_o pulse, result_o unchanged.
  - flush_i takes priority over the DONE→IDLE pulse cycle: a DONE state still emits done_o that cycle, because done_o is decoded from state.
  - flush_i with start_i in IDLE: start is ignored.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN
- Defined:
  - Divide by zero, signed overflow, and multiply with either operand zero bypass CALC/FIX. IDLE→DONE at the accept edge with result_o loaded with the special value (0 for multiply by zero).
  - done_o is high between edges 0 and 1; ready_o returns after edge 1.
- Undefined: every operation takes the full 34-cycle latency. Result values are identical in both builds.

Test Plan:
- MUL op_a=7, op_b=6 -> done_o after edge 33, result_o=42; ready_o=0 for cycles 1..34.
- MULH op_a=0xFFFFFFFE (-2), op_b=3 -> result_o=0xFFFFFFFF. MULHU with the same operands -> 0x00000002. MULHSU op_a=-1, op_b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV op_a=-7, op_b=2 -> 0xFFFFFFFD (-3). REM with the same operands -> 0xFFFFFFFF (-1). REMU op_a=7, op_b=2 -> 1.
- DIVU op_a=5, op_b=0 -> 0xFFFFFFFF. REM op_a=5, op_b=0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. Latency is 34 edges, or 1 edge with MULDIV_EARLY_OUT_EN.
- Start a DIV, assert flush_i at cycle 10 -> IDLE next edge, no done_o, result_o keeps its prior value. A new MUL 3*3 then returns 9.
- Start a MUL, assert rst_i asynchronously mid-CALC -> all outputs return to reset values immediately. start_i pulsed while busy -> ignored; only the first result (9) is produced.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Optional macro MULDIV_EARLY_OUT_EN: zero/overflow operands finish directly from IDLE.
module muldiv_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    input  logic            flush_i,
    output logic            ready_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          funct3_q, funct3_d;
    logic                neg_q, neg_d;
    logic [XLEN-1:0]     opd_q, opd_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     result_q, result_d;

    logic            signedA, signedB, aNeg, bNeg, isDivIn, bZero, negIn;
    logic [XLEN-1:0] aMag, bMag;
    logic [XLEN:0]   mulSum, divTrial;
    logic [2*XLEN-1:0] mulNext, divNext, prodFinal;
    logic [XLEN-1:0] quotFinal, remFinal, fixVal;

    // Operand conditioning at acceptance: magnitudes plus the sign the result must carry.
    assign signedA = (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                     (funct3_i == 3'b100) || (funct3_i == 3'b110);
    assign signedB = (funct3_i == 3'b001) || (funct3_i == 3'b100) || (funct3_i == 3'b110);
    assign aNeg    = signedA && op_a_i[XLEN-1];
    assign bNeg    = signedB && op_b_i[XLEN-1];
    assign aMag    = aNeg ? -op_a_i : op_a_i;
    assign bMag    = bNeg ? -op_b_i : op_b_i;
    assign isDivIn = funct3_i[2];
    assign bZero   = (op_b_i == '0);

    // A zero divisor must leave the all-ones quotient and the dividend remainder untouched.
    always_comb begin
        negIn = 1'b0;
        if (isDivIn) begin
            negIn = funct3_i[1] ? aNeg : ((aNeg ^ bNeg) && !bZero);
        end else if (funct3_i != 3'b000) begin
            negIn = aNeg ^ bNeg;
        end
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic            ovf, earlyHit;
    logic [XLEN-1:0] earlyVal;

    assign ovf = !funct3_i[0] && (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (&op_b_i);

    always_comb begin
        earlyHit = 1'b0;
        earlyVal = '0;
        if (!isDivIn) begin
            earlyHit = (op_a_i == '0) || bZero;
        end else if (bZero) begin
            earlyHit = 1'b1;
            earlyVal = funct3_i[1] ? op_a_i : '1;
        end else if (ovf) begin
            earlyHit = 1'b1;
            earlyVal = funct3_i[1] ? '0 : op_a_i;
        end
    end
`endif

    assign mulSum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opd_q} : '0);
    assign mulNext  = {mulSum, acc_q[XLEN-1:1]};
    assign divTrial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opd_q};
    assign divNext  = divTrial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                     : {divTrial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    assign prodFinal = neg_q ? -acc_q : acc_q;
    assign quotFinal = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign remFinal  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    always_comb begin
        if (!funct3_q[2]) begin
            fixVal = (funct3_q[1:0] == 2'b00) ? prodFinal[XLEN-1:0] : prodFinal[2*XLEN-1:XLEN];
        end else begin
            fixVal = funct3_q[1] ? remFinal : quotFinal;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            funct3_q <= '0;
            neg_q    <= 1'b0;
            opd_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            funct3_q <= funct3_d;
            neg_q    <= neg_d;
            opd_q    <= opd_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    // Flush wins in every busy state; DONE still shows done_o because it is decoded from state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        funct3_d = funct3_q;
        neg_d    = neg_q;
        opd_d    = opd_q;
        acc_d    = acc_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start_i && !flush_i) begin
                    funct3_d = funct3_i;
                    neg_d    = negIn;
                    cnt_d    = '0;
                    opd_d    = isDivIn ? bMag : aMag;
                    acc_d    = {{XLEN{1'b0}}, (isDivIn ? aMag : bMag)};
                    state_d  = CALC;
`ifdef MULDIV_EARLY_OUT_EN
                    if (earlyHit) begin
                        result_d = earlyVal;
                        state_d  = DONE;
                    end
`endif
                end
            end
            CALC: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    acc_d = funct3_q[2] ? divNext : mulNext;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(XLEN-1)) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    result_d = fixVal;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign ready_o  = (state_q == IDLE);
    assign busy_o   = (state_q != IDLE);
    assign done_o   = (state_q == DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer against an arithmetic reference model.
module tb_muldiv_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        flush;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EarlyOut = 1'b1;
`else
    localparam bit EarlyOut = 1'b0;
`endif

    muldiv_sequencer dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .funct3_i (funct3),
        .op_a_i   (opA),
        .op_b_i   (opB),
        .flush_i  (flush),
        .ready_o  (ready),
        .busy_o   (busy),
        .done_o   (done),
        .result_o (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference results straight from the RV32M definitions using 64-bit arithmetic.
    function automatic logic [31:0] refModel(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
        longint sa, sb, p;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f)
            3'd0: begin up = ua * ub; return up[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin up = ua * ub; return up[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                up = ua / ub; return up[31:0];
            end
            3'd6: begin
                if (b == 32'd0) return a;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                up = ua % ub; return up[31:0];
            end
        endcase
    endfunction

    function automatic bit isSpecial(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
        if (!f[2]) return (a == 32'd0) || (b == 32'd0);
        if (b == 32'd0) return 1'b1;
        return !f[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    endfunction

    function automatic int expectedDoneEdge(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
        return (EarlyOut && isSpecial(f, a, b)) ? 0 : 33;
    endfunction

    // Issues one operation and reports the edge (after acceptance) at which done_o appeared.
    task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                 output int doneEdge, output logic [31:0] res,
                                 output bit readyLeak, output logic doneAfter,
                                 output logic readyAfter);
        int edgeNo;
        @(negedge clk);
        start  = 1'b1;
        funct3 = f;
        opA    = a;
        opB    = b;
        @(posedge clk);
        #1;
        start     = 1'b0;
        opA       = $urandom;
        opB       = $urandom;
        funct3    = 3'($urandom_range(0, 7));
        doneEdge  = -1;
        res       = 'x;
        readyLeak = 1'b0;
        edgeNo    = 0;
        while (edgeNo <= 60) begin
            if (done === 1'b1) begin
                doneEdge = edgeNo;
                res      = result;
                break;
            end
            if (ready !== 1'b0) readyLeak = 1'b1;
            @(posedge clk);
            edgeNo++;
            #1;
        end
        @(posedge clk);
        #1;
        doneAfter  = done;
        readyAfter = ready;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        checks++;
        if (ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", ready); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++;
        if (result !== 32'd0) begin errors++; $display("[TB] FAIL reset_result: got %h expected 0", result); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (ready !== 1'b1) begin errors++; $display("[TB] FAIL idle_ready: got %b expected 1", ready); end
    endtask

    task automatic test_vectors();
        logic [2:0]  vf[14] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd7,
                                3'd5, 3'd6, 3'd4, 3'd6, 3'd0, 3'd4, 3'd6};
        logic [31:0] va[14] = '{32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                                32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd5, 32'd5,
                                32'h8000_0000, 32'h8000_0000, 32'd0,
                                32'hFFFF_FFF9, 32'hFFFF_FFF9};
        logic [31:0] vb[14] = '{32'd6, 32'd3, 32'd3, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2,
                                32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd12345,
                                32'd0, 32'd0};
        logic [31:0] ve[14] = '{32'd42, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF,
                                32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd5,
                                32'h8000_0000, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
        int doneEdge;
        logic [31:0] res;
        bit readyLeak;
        logic doneAfter, readyAfter;
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vf[i], va[i], vb[i], doneEdge, res, readyLeak, doneAfter, readyAfter);
            checks++;
            if (res !== ve[i]) begin
                errors++;
                $display("[TB] FAIL vector%0d_result: got %h expected %h", i, res, ve[i]);
            end
            checks++;
            if (doneEdge != expectedDoneEdge(vf[i], va[i], vb[i])) begin
                errors++;
                $display("[TB] FAIL vector%0d_latency: got %0d expected %0d", i, doneEdge,
                         expectedDoneEdge(vf[i], va[i], vb[i]));
            end
            checks++;
            if (readyLeak || doneAfter !== 1'b0 || readyAfter !== 1'b1) begin
                errors++;
                $display("[TB] FAIL vector%0d_handshake: got leak=%b done=%b ready=%b expected 0 0 1",
                         i, readyLeak, doneAfter, readyAfter);
            end
        end
    endtask

    task automatic test_random();
        int doneEdge;
        logic [31:0] res, a, b, exp;
        logic [2:0] f;
        bit readyLeak;
        logic doneAfter, readyAfter;
        for (int i = 0; i < 48; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: a = 32'd0;
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            exp = refModel(f, a, b);
            applyStimulus(f, a, b, doneEdge, res, readyLeak, doneAfter, readyAfter);
            checks++;
            if (res !== exp || doneEdge != expectedDoneEdge(f, a, b)) begin
                errors++;
                $display("[TB] FAIL random%0d f=%0d a=%h b=%h: got %h at edge %0d expected %h at edge %0d",
                         i, f, a, b, res, doneEdge, exp, expectedDoneEdge(f, a, b));
            end
        end
    endtask

    task automatic test_flush();
        logic [31:0] prior;
        int pulses;
        int doneEdge;
        logic [31:0] res;
        bit readyLeak;
        logic doneAfter, readyAfter;
        prior = result;
        @(negedge clk);
        start = 1'b1; funct3 = 3'd4; opA = 32'd1000; opB = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checks++;
        if (ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_idle: got ready=%b busy=%b expected 1 0", ready, busy);
        end
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || result !== prior) begin
            errors++;
            $display("[TB] FAIL flush_no_done: got pulses=%0d result=%h expected 0 %h", pulses, result, prior);
        end
        @(negedge clk);
        start = 1'b1; flush = 1'b1; funct3 = 3'd0; opA = 32'd4; opB = 32'd4;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flush_blocks_start: got ready=%b expected 1", ready);
        end
        applyStimulus(3'd0, 32'd3, 32'd3, doneEdge, res, readyLeak, doneAfter, readyAfter);
        checks++;
        if (res !== 32'd9) begin
            errors++;
            $display("[TB] FAIL flush_then_mul: got %h expected 00000009", res);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; opA = 32'd11; opB = 32'd13;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            errors++;
            $display("[TB] FAIL async_reset: got ready=%b busy=%b done=%b result=%h expected 1 0 0 0",
                     ready, busy, done, result);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        int pulses;
        logic [31:0] seen;
        int doneEdge;
        logic [31:0] res;
        bit readyLeak;
        logic doneAfter, readyAfter;
        logic [31:0] a[3] = '{32'd100, 32'hFFFF_FF00, 32'd81};
        logic [31:0] b[3] = '{32'd9, 32'd16, 32'd0};
        logic [2:0]  f[3] = '{3'd5, 3'd4, 3'd7};
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; opA = 32'd3; opB = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; opA = 32'd5; opB = 32'd5;
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        seen = 32'd0;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin pulses++; seen = result; end
        end
        checks++;
        if (pulses != 1 || seen !== 32'd9) begin
            errors++;
            $display("[TB] FAIL busy_start_ignored: got pulses=%0d result=%h expected 1 00000009", pulses, seen);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(f[i], a[i], b[i], doneEdge, res, readyLeak, doneAfter, readyAfter);
            checks++;
            if (res !== refModel(f[i], a[i], b[i])) begin
                errors++;
                $display("[TB] FAIL back_to_back%0d: got %h expected %h", i, res, refModel(f[i], a[i], b[i]));
            end
        end
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'd0; opA = 32'd0; opB = 32'd0;
        test_reset();
        test_vectors();
        test_random();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
